leaky_maxpool2x2_int16: RTL and testbench

//  Downstream stage of the int16 conv2D core. Consumes the raster-ordered conv result

---
 rtl/leaky_maxpool2x2_int16.sv | 144 ++++++++++++++
 tb/tb_leaky_maxpool2x2_int16.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/leaky_maxpool2x2_int16.sv
`default_nettype none
// ============================================================================
// Module   : leaky_maxpool2x2_int16
// Purpose  : Leaky ReLU followed by 2x2/stride-2 max-pool on a raster AXIS stream.
// Revision : 1.0
// ============================================================================
module leaky_maxpool2x2_int16 #(
    parameter int DATA_W     = 16,
    parameter int MAX_W      = 64,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_W      = 16
) (
    input  logic              AXIS_ACLK,
    input  logic              AXIS_ARESET,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic [CNT_W-1:0]  cfg_height,
    output logic              S_AXIS_TREADY,
    input  logic [DATA_W-1:0] S_AXIS_TDATA,
    input  logic [1:0]        S_AXIS_TKEEP,
    input  logic              S_AXIS_TLAST,
    input  logic              S_AXIS_TVALID,
    output logic              M_AXIS_TVALID,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic [1:0]        M_AXIS_TKEEP,
    output logic              M_AXIS_TLAST,
    input  logic              M_AXIS_TREADY,
    output logic              err_tlast
);
    localparam int IDX_W = $clog2(MAX_W / 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         width_q, height_q;
    logic [CNT_W-1:0]         col_q, col_d, row_q, row_d;
    logic signed [DATA_W-1:0] pair_q;
    logic signed [DATA_W-1:0] lbuf_q [MAX_W/2];
    logic                     m_valid_q, m_last_q, err_q;
    logic signed [DATA_W-1:0] m_data_q;

    logic                     w_ready, w_rx, w_beat;
    logic [CNT_W-1:0]         w_width, w_height;
    logic                     w_col_last, w_row_last, w_frame_last;
    logic signed [DATA_W-1:0] w_x, w_act, w_pair_max, w_line, w_pool;
    logic [IDX_W-1:0]         w_idx;
    logic                     w_load, w_last_out, w_tlast_bad;

    assign w_ready = (state_q != S_DRAIN) & (~m_valid_q | M_AXIS_TREADY);
    assign w_rx    = S_AXIS_TVALID & w_ready;
    assign w_beat  = w_rx & (S_AXIS_TKEEP == 2'b11);

    // The first beat of a frame uses the live cfg ports, later beats the latched copy.
    assign w_width      = (state_q == S_IDLE) ? cfg_width  : width_q;
    assign w_height     = (state_q == S_IDLE) ? cfg_height : height_q;
    assign w_col_last   = (col_q == w_width  - CNT_W'(1));
    assign w_row_last   = (row_q == w_height - CNT_W'(1));
    assign w_frame_last = w_col_last & w_row_last;

    assign w_x        = S_AXIS_TDATA;
    assign w_act      = w_x[DATA_W-1] ? (w_x >>> LEAK_SHIFT) : w_x;
    assign w_pair_max = (pair_q > w_act) ? pair_q : w_act;
    assign w_idx      = col_q[IDX_W:1];
    assign w_line     = lbuf_q[w_idx];
    assign w_pool     = (w_line > w_pair_max) ? w_line : w_pair_max;

    // Last pooled value sits at the last odd column of the last odd row (odd W/H drop a tail).
    assign w_load     = w_beat & col_q[0] & row_q[0];
    assign w_last_out = (col_q == {w_width[CNT_W-1:1], 1'b0} - CNT_W'(1)) &
                        (row_q == {w_height[CNT_W-1:1], 1'b0} - CNT_W'(1));

    assign w_tlast_bad = w_rx & (w_beat ? (S_AXIS_TLAST != w_frame_last) : S_AXIS_TLAST);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (w_beat) begin
            if (w_frame_last) begin
                col_d = '0;
                row_d = '0;
            end else if (w_col_last) begin
                col_d = '0;
                row_d = row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
        case (state_q)
            S_IDLE:  if (w_beat) state_d = S_RUN;
            S_RUN:   if (w_beat & w_frame_last) state_d = S_DRAIN;
            S_DRAIN: if (~m_valid_q | (M_AXIS_TREADY & m_last_q)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            state_q   <= S_IDLE;
            width_q   <= '0;
            height_q  <= '0;
            col_q     <= '0;
            row_q     <= '0;
            pair_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            if ((state_q == S_IDLE) && w_beat) begin
                width_q  <= cfg_width;
                height_q <= cfg_height;
            end
            if (w_beat & ~col_q[0]) pair_q <= w_act;
            if (w_load) begin
                m_valid_q <= 1'b1;
                m_data_q  <= w_pool;
                m_last_q  <= w_last_out;
            end else if (M_AXIS_TREADY) begin
                m_valid_q <= 1'b0;
            end
            if (w_tlast_bad) err_q <= 1'b1;
        end
    end

    // Not reset: every even row rewrites the entries before an odd row reads them.
    always_ff @(posedge AXIS_ACLK) begin
        if (w_beat & col_q[0] & ~row_q[0]) lbuf_q[w_idx] <= w_pair_max;
    end

    assign S_AXIS_TREADY = w_ready;
    assign M_AXIS_TVALID = m_valid_q;
    assign M_AXIS_TDATA  = m_data_q;
    assign M_AXIS_TLAST  = m_last_q;
    assign M_AXIS_TKEEP  = 2'b11;
    assign err_tlast     = err_q;
endmodule
`default_nettype wire

// File: tb/tb_leaky_maxpool2x2_int16.sv
`default_nettype none
// ============================================================================
// Module   : tb_leaky_maxpool2x2_int16
// Purpose  : Directed and randomized checks of the leaky-ReLU 2x2 max-pool stage.
// Revision : 1.0
// ============================================================================
module tb_leaky_maxpool2x2_int16;
    localparam int MAX_W = 64;
    localparam int LEAK  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_w = 16'd2, cfg_h = 16'd2;
    logic        s_tready;
    logic [15:0] s_tdata = '0;
    logic [1:0]  s_tkeep = 2'b11;
    logic        s_tlast = 1'b0, s_tvalid = 1'b0;
    logic        m_tvalid, m_tlast, err;
    logic [15:0] m_tdata;
    logic [1:0]  m_tkeep;
    logic        m_tready = 1'b1;

    int          errors = 0, checks = 0;
    int          ready_mode = 0;
    logic        ready_force = 1'b1;
    logic [16:0] out_q[$];
    int          in_vals[$];
    int          exp_q[$];

    always #5 clk = ~clk;

    leaky_maxpool2x2_int16 #(.DATA_W(16), .MAX_W(MAX_W), .LEAK_SHIFT(LEAK), .CNT_W(16)) dut (
        .AXIS_ACLK(clk), .AXIS_ARESET(rst), .cfg_width(cfg_w), .cfg_height(cfg_h),
        .S_AXIS_TREADY(s_tready), .S_AXIS_TDATA(s_tdata), .S_AXIS_TKEEP(s_tkeep),
        .S_AXIS_TLAST(s_tlast), .S_AXIS_TVALID(s_tvalid),
        .M_AXIS_TVALID(m_tvalid), .M_AXIS_TDATA(m_tdata), .M_AXIS_TKEEP(m_tkeep),
        .M_AXIS_TLAST(m_tlast), .M_AXIS_TREADY(m_tready), .err_tlast(err));

    always @(posedge clk) begin
        #1;
        m_tready = (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    // Signals are stable between posedge+1 and the next posedge, so a handshake seen here completes.
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) out_q.push_back({m_tlast, m_tdata});
    end

    function automatic int leaky(input int x);
        if (x >= 0) return x;
        return (x - (2**LEAK - 1)) / (2**LEAK);
    endfunction

    task automatic build_expected(input int w, input int h);
        exp_q.delete();
        for (int r = 0; r < h / 2; r++)
            for (int c = 0; c < w / 2; c++) begin
                int mx = -100000;
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++) begin
                        int v = leaky(in_vals[(2*r+dr)*w + 2*c+dc]);
                        if (v > mx) mx = v;
                    end
                exp_q.push_back(mx);
            end
    endtask

    task automatic send_beat(input logic [15:0] d, input logic [1:0] k, input logic l);
        s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (s_tready) break;
            if (n > 2000) begin
                checks++; errors++;
                $display("FAIL send_timeout got tready=%b required=1", s_tready);
                break;
            end
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = 2'b11;
    endtask

    task automatic run_frame(input int w, input int h, input bit gaps, input int bad_idx);
        cfg_w = 16'(w); cfg_h = 16'(h);
        out_q.delete();
        for (int i = 0; i < w * h; i++) begin
            if (gaps && $urandom_range(0, 3) == 0)
                send_beat(16'($urandom), 2'($urandom_range(0, 2)), 1'b0);
            send_beat(16'(in_vals[i]), 2'b11, (i == w*h-1) || (i == bad_idx));
        end
        for (int n = 0; n < 5000 && out_q.size() < (w/2)*(h/2); n++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b required=0", m_tvalid); end
        checks++; if (m_tdata !== 16'd0) begin errors++; $display("FAIL reset_tdata got=%0h required=0", m_tdata); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b required=0", m_tlast); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b required=0", err); end
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_tready got=%b required=1", s_tready); end
        checks++; if (m_tkeep !== 2'b11) begin errors++; $display("FAIL reset_tkeep got=%b required=11", m_tkeep); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp();
        in_vals.delete();
        for (int i = 0; i < 16; i++) in_vals.push_back(i);
        exp_q = '{5, 7, 13, 15};
        run_frame(4, 4, 0, -1);
        checks++; if (out_q.size() != exp_q.size()) begin errors++; $display("FAIL ramp_count got=%0d required=%0d", out_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < out_q.size()) begin
            checks++;
            if (out_q[i] !== {i == exp_q.size()-1, 16'(exp_q[i])}) begin errors++; $display("FAIL ramp_out%0d got=%h required=%h", i, out_q[i], {i == exp_q.size()-1, 16'(exp_q[i])}); end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ramp_err got=%b required=0", err); end
    endtask

    task automatic test_leaky();
        in_vals = '{-80, -16, -8, -800};
        run_frame(2, 2, 0, -1);
        checks++; if (out_q.size() != 1) begin errors++; $display("FAIL leaky_count got=%0d required=1", out_q.size()); end
        if (out_q.size() > 0) begin
            checks++; if (out_q[0] !== {1'b1, 16'hFFFF}) begin errors++; $display("FAIL leaky_out got=%h required=%h", out_q[0], {1'b1, 16'hFFFF}); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        ready_force = 1'b0;
        @(posedge clk); #2;
        cfg_w = 16'd4; cfg_h = 16'd2;
        out_q.delete();
        fork
            for (int i = 0; i < 8; i++) send_beat(16'(i), 2'b11, i == 7);
            begin
                for (int n = 0; n < 200 && !m_tvalid; n++) @(negedge clk);
                held = m_tdata;
                checks++; if (held !== 16'd5) begin errors++; $display("FAIL bp_first got=%0d required=5", held); end
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    checks++;
                    if (!(m_tvalid === 1'b1 && m_tdata === held && s_tready === 1'b0)) begin
                        errors++; $display("FAIL bp_hold cyc%0d got v=%b d=%0d rdy=%b required v=1 d=%0d rdy=0", c, m_tvalid, m_tdata, s_tready, held);
                    end
                end
                ready_force = 1'b1;
            end
        join
        for (int n = 0; n < 200 && out_q.size() < 2; n++) @(posedge clk);
        repeat (5) @(posedge clk); #1;
        exp_q = '{5, 7};
        checks++; if (out_q.size() != 2) begin errors++; $display("FAIL bp_count got=%0d required=2", out_q.size()); end
        foreach (exp_q[i]) if (i < out_q.size()) begin
            checks++;
            if (out_q[i] !== {i == 1, 16'(exp_q[i])}) begin errors++; $display("FAIL bp_out%0d got=%h required=%h", i, out_q[i], {i == 1, 16'(exp_q[i])}); end
        end
    endtask

    task automatic test_odd();
        in_vals.delete();
        for (int i = 0; i < 15; i++) in_vals.push_back(i);
        exp_q = '{6, 8};
        run_frame(5, 3, 0, -1);
        checks++; if (out_q.size() != 2) begin errors++; $display("FAIL odd_count got=%0d required=2", out_q.size()); end
        foreach (exp_q[i]) if (i < out_q.size()) begin
            checks++;
            if (out_q[i] !== {i == 1, 16'(exp_q[i])}) begin errors++; $display("FAIL odd_out%0d got=%h required=%h", i, out_q[i], {i == 1, 16'(exp_q[i])}); end
        end
        in_vals = '{10, 20, 30, 40};
        run_frame(2, 2, 0, -1);
        checks++; if (out_q.size() != 1 || out_q[0] !== {1'b1, 16'd40}) begin errors++; $display("FAIL odd_next got=%h required=%h", (out_q.size() > 0) ? out_q[0] : 17'h0, {1'b1, 16'd40}); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL odd_err got=%b required=0", err); end
    endtask

    task automatic test_random();
        ready_mode = 1;
        for (int f = 0; f < 6; f++) begin
            int w = (f == 0) ? MAX_W : $urandom_range(2, 12);
            int h = (f == 0) ? 2 : $urandom_range(2, 6);
            in_vals.delete();
            for (int i = 0; i < w * h; i++) in_vals.push_back(int'($urandom_range(0, 65535)) - 32768);
            build_expected(w, h);
            run_frame(w, h, 1, -1);
            checks++; if (out_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count got=%0d required=%0d", f, out_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < out_q.size()) begin
                checks++;
                if (out_q[i] !== {i == exp_q.size()-1, 16'(exp_q[i])}) begin errors++; $display("FAIL rand%0d_out%0d got=%h required=%h", f, i, out_q[i], {i == exp_q.size()-1, 16'(exp_q[i])}); end
            end
        end
        ready_mode = 0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rand_err got=%b required=0", err); end
    endtask

    task automatic test_tlast_err();
        in_vals.delete();
        for (int i = 0; i < 16; i++) in_vals.push_back(i);
        exp_q = '{5, 7, 13, 15};
        run_frame(4, 4, 0, 7);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tlast_err_flag got=%b required=1", err); end
        checks++; if (out_q.size() != 4) begin errors++; $display("FAIL tlast_err_count got=%0d required=4", out_q.size()); end
        foreach (exp_q[i]) if (i < out_q.size()) begin
            checks++;
            if (out_q[i] !== {i == 3, 16'(exp_q[i])}) begin errors++; $display("FAIL tlast_err_out%0d got=%h required=%h", i, out_q[i], {i == 3, 16'(exp_q[i])}); end
        end
        in_vals = '{1, 2, 3, 4};
        run_frame(2, 2, 0, -1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tlast_err_sticky got=%b required=1", err); end
    endtask

    task automatic test_reset_midframe();
        ready_force = 1'b0;
        @(posedge clk); #2;
        cfg_w = 16'd4; cfg_h = 16'd4;
        for (int i = 0; i < 6; i++) send_beat(16'(i), 2'b11, 1'b0);
        @(negedge clk);
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL mid_pending got=%b required=1", m_tvalid); end
        rst = 1'b1;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== 16'd0 || m_tlast !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL mid_async got v=%b d=%h l=%b e=%b required all 0", m_tvalid, m_tdata, m_tlast, err);
        end
        ready_force = 1'b1;
        repeat (2) @(posedge clk);
        #2; rst = 1'b0;
        @(posedge clk); #1;
        in_vals = '{1, 2, 3, 4};
        run_frame(2, 2, 0, -1);
        checks++; if (out_q.size() != 1 || out_q[0] !== {1'b1, 16'd4}) begin errors++; $display("FAIL mid_fresh got=%h required=%h", (out_q.size() > 0) ? out_q[0] : 17'h0, {1'b1, 16'd4}); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err got=%b required=0", err); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_leaky();
        test_backpressure();
        test_odd();
        test_random();
        test_tlast_err();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
